// File: rtl/rom_burst_reader.sv
// rom_burst_reader
//
// Reads a burst of consecutive words from a small constant ROM and presents
// them on a registered valid/ready output port.
//
// Word a of the ROM holds (a*5 + 3) mod 2^DATA_W for a in 0..DEPTH-1.
// A burst is requested in IDLE with start=1. If start_addr is in range, the
// block moves to RUN. It then streams burst_len+1 words, starting at
// start_addr and wrapping from DEPTH-1 back to 0. An out-of-range request is
// rejected: err is raised and done pulses, and no data is produced.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   burst request, sampled only while idle
//   start_addr  in   [ADDR_W] first word address
//   burst_len   in   [LEN_W]  words in burst minus one
//   dout_ready  in   consumer accepts dout this cycle
//   dout        out  [DATA_W] registered read data, retained when not valid
//   dout_valid  out  dout holds a word not yet accepted
//   busy        out  burst in progress
//   done        out  one-cycle pulse after the last word is accepted or a
//                    request is rejected
//   err         out  last request was rejected; cleared by the next
//                    accepted start

module rom_burst_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // The ROM spans the full address space. Entries at or beyond DEPTH are
    // never addressed. They exist only so that indexing with addr_q never
    // leaves the array.
    localparam int unsigned SPAN = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    // Words still to be read from the ROM. This needs one extra bit because
    // a full burst holds 2^LEN_W words.
    logic [LEN_W:0]    remaining_q;

    logic              addr_ok;
    logic              issue;
    logic [ADDR_W-1:0] next_addr;

    logic [DATA_W-1:0] rom [SPAN];

    for (genvar a = 0; a < SPAN; a++) begin : g_rom
        if (a < DEPTH) begin : g_word
            assign rom[a] = DATA_W'(a * 5 + 3);
        end else begin : g_pad
            assign rom[a] = '0;
        end
    end

    always_comb begin
        addr_ok = ({1'b0, start_addr} < DEPTH_LIM);
    end

    // A read goes out whenever words remain and the output register is free.
    // The register is free when it is empty or when it is being emptied on
    // this same edge. This gives back-to-back words with no bubble.
    always_comb begin
        issue = 1'b0;
        if ((state_q == StRun) && (remaining_q != '0) && (!dout_valid || dout_ready)) begin
            issue = 1'b1;
        end
    end

    always_comb begin
        next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (addr_ok) begin
                            state_q     <= StRun;
                            addr_q      <= start_addr;
                            remaining_q <= (LEN_W + 1)'(burst_len) + (LEN_W + 1)'(1);
                            busy        <= 1'b1;
                            err         <= 1'b0;
                        end else begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end
                    end
                end

                StRun: begin
                    if (issue) begin
                        dout        <= rom[addr_q];
                        dout_valid  <= 1'b1;
                        addr_q      <= next_addr;
                        remaining_q <= remaining_q - (LEN_W + 1)'(1);
                    end else if (dout_valid && dout_ready) begin
                        // The final word is being accepted and nothing is
                        // left to read. dout keeps its value after this.
                        dout_valid <= 1'b0;
                        if (remaining_q == '0) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Testbench for rom_burst_reader.
// Instance a uses the default parameters (DEPTH=16).
// Instance b uses DEPTH=12 to exercise out-of-range requests.
// Both instances share all inputs; use_b selects which one is checked.
// After each clock edge the outputs are sampled, and the inputs for the
// next edge are driven, 1 time unit after the edge.

module tb_rom_burst_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [3:0] burst_len;
    logic       dout_ready;

    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

    logic       use_b;
    logic [7:0] s_dout;
    logic       s_valid, s_busy, s_done, s_err;

    int checks = 0;
    int errors = 0;

    rom_burst_reader #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(16), .LEN_W(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .burst_len(burst_len), .dout_ready(dout_ready), .dout(dout_a),
        .dout_valid(valid_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    rom_burst_reader #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(12), .LEN_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .burst_len(burst_len), .dout_ready(dout_ready), .dout(dout_b),
        .dout_valid(valid_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        s_dout  = use_b ? dout_b  : dout_a;
        s_valid = use_b ? valid_b : valid_a;
        s_busy  = use_b ? busy_b  : busy_a;
        s_done  = use_b ? done_b  : done_a;
        s_err   = use_b ? err_b   : err_a;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog observed=running expected=finished");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"},  32'(s_dout),  0);
        chk({tag, "_valid"}, 32'(s_valid), 0);
        chk({tag, "_busy"},  32'(s_busy),  0);
        chk({tag, "_done"},  32'(s_done),  0);
        chk({tag, "_err"},   32'(s_err),   0);
    endtask

    // Reference contents: word a = (a*5+3) mod 256.
    function automatic int rom_word(input int a);
        return (a * 5 + 3) % 256;
    endfunction

    // Hold reset for two edges with start and ready active; everything must
    // stay zero.
    task automatic do_reset(input string tag);
        rst_n = 1'b0; start = 1'b1; dout_ready = 1'b1; start_addr = 4'd2; burst_len = 4'd3;
        step();
        chk_zero({tag, "_r1"});
        step();
        chk_zero({tag, "_r2"});
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    // One burst request. mode 0: ready always high.
    // mode 1: random ready plus random start requests while busy.
    // mode 2: ready low for 3 cycles while the second word is shown.
    task automatic run_burst(input int addr, input int len, input int mode);
        int depth;
        int q[$];
        int idx;
        int stalls;
        int cyc;
        bit rdy;
        depth = use_b ? 12 : 16;
        start = 1'b1; start_addr = addr[3:0]; burst_len = len[3:0]; dout_ready = 1'b1;
        step();
        start = 1'b0;
        if (addr >= depth) begin
            chk("rej_err",   32'(s_err),   1);
            chk("rej_done",  32'(s_done),  1);
            chk("rej_valid", 32'(s_valid), 0);
            chk("rej_busy",  32'(s_busy),  0);
            step();
            chk("rej_done_drop", 32'(s_done),  0);
            chk("rej_err_hold",  32'(s_err),   1);
            chk("rej_valid2",    32'(s_valid), 0);
            return;
        end
        chk("acc_busy",  32'(s_busy),  1);
        chk("acc_err",   32'(s_err),   0);
        chk("acc_valid", 32'(s_valid), 0);
        chk("acc_done",  32'(s_done),  0);
        for (int i = 0; i <= len; i++) q.push_back(rom_word((addr + i) % depth));
        step();
        chk("first_valid", 32'(s_valid), 1);
        idx = 0; stalls = 0; cyc = 0;
        while (1) begin
            // Until the last word is taken the port is never empty, and it
            // always shows the next word in order.
            chk("word_valid", 32'(s_valid), 1);
            chk("word_data",  32'(s_dout),  q[idx]);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = !(idx == 1 && stalls < 3);
                    if (!rdy) stalls++;
                end
            endcase
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                start_addr = 4'($urandom);
                burst_len = 4'($urandom);
            end
            dout_ready = rdy;
            step();
            cyc++;
            if (rdy) idx++;
            if (idx == q.size()) begin
                chk("end_done",  32'(s_done),  1);
                chk("end_busy",  32'(s_busy),  0);
                chk("end_valid", 32'(s_valid), 0);
                chk("end_err",   32'(s_err),   0);
                chk("end_retain", 32'(s_dout), q[q.size() - 1]);
                break;
            end
            chk("mid_done", 32'(s_done), 0);
            chk("mid_busy", 32'(s_busy), 1);
            chk("mid_err",  32'(s_err),  0);
            if (cyc > 200) begin
                chk("burst_timeout", 0, 1);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            step();
            chk("idle_done",  32'(s_done),  0);
            chk("idle_busy",  32'(s_busy),  0);
            chk("idle_valid", 32'(s_valid), 0);
        end
    endtask

    initial begin
        use_b = 1'b0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0; dout_ready = 1'b1;

        do_reset("reset_a");

        // Single read, then a wrapping burst back to back, then backpressure.
        run_burst(2, 0, 0);
        run_burst(14, 3, 0);
        run_burst(0, 4, 2);
        idle_steps(2);

        for (int n = 0; n < 25; n++) begin
            run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 2)));
            idle_steps(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a long burst: no done pulse.
        start = 1'b1; start_addr = 4'd3; burst_len = 4'd7; dout_ready = 1'b1;
        step();
        start = 1'b1; start_addr = 4'd0;
        step();
        step();
        step();
        rst_n = 1'b0; start = 1'b1;
        step();
        chk_zero("midrst");
        rst_n = 1'b1; start = 1'b0;
        step();
        chk("midrst_nodone", 32'(s_done),  0);
        chk("midrst_busy",   32'(s_busy),  0);
        chk("midrst_valid",  32'(s_valid), 0);
        run_burst(5, 2, 1);

        // Instance with DEPTH=12: range errors and wrap at 11.
        use_b = 1'b1;
        do_reset("reset_b");
        run_burst(13, 0, 0);
        run_burst(4, 2, 0);
        run_burst(12, 5, 0);
        run_burst(15, 1, 0);
        run_burst(10, 3, 1);
        for (int n = 0; n < 15; n++) begin
            run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 2)));
            idle_steps(int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
